// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
// Module   : rr_mux_arbiter_pkg
// Brief    : Shared FSM encodings and defaults for the round-robin mux arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_mux_arbiter_pkg;

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  localparam int c_HOLD_MAX_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Rotating-priority picker: first set req bit at or above ptr, wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  assign any = |req;

  // Scan from farthest to nearest so the nearest set bit is the last writer.
  always_comb begin
    logic [1:0] w_cand;
    idx    = '0;
    w_cand = '0;
    for (int i = 3; i >= 0; i--) begin
      w_cand = ptr + 2'(i);
      if (req[w_cand]) idx = w_cand;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module   : rr_mux_arbiter
// Brief    : Four-way round-robin arbiter muxing one requester onto a valid/ready sink.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DW       = 2,
  parameter int HOLD_MAX = c_HOLD_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  output logic [N_REQ-1:0]    ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [1:0]          out_sel,
  output logic                busy
);

  localparam logic [3:0] c_CNT_LAST = 4'(HOLD_MAX - 1);

  logic [0:0] r_state;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [3:0] r_cnt;

  logic [1:0] w_idx;
  logic       w_any;
  logic       w_grant;
  logic       w_accept;

  rr_pick u_pick (
    .req (req),
    .ptr (r_ptr),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_grant   = (r_state == c_GRANT);
  assign out_valid = w_grant & req[r_sel];
  // rst_n gates acceptance so a grant aborted by reset never acknowledges.
  assign w_accept  = out_valid & out_ready & rst_n;
  assign out_sel   = r_sel;
  assign busy      = w_grant;

  always_comb begin
    out_data = '0;
    if (w_grant) begin
      case (r_sel)
        2'd0:    out_data = din[DW-1:0];
        2'd1:    out_data = din[2*DW-1:DW];
        2'd2:    out_data = din[3*DW-1:2*DW];
        2'd3:    out_data = din[4*DW-1:3*DW];
        default: out_data = '0;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (w_accept) ack[r_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_sel   <= w_idx;
            r_cnt   <= '0;
            r_state <= c_GRANT;
          end
        end
        c_GRANT: begin
          // A dropped request releases immediately; any unaccepted beat is lost.
          if (!req[r_sel] || (w_accept && r_cnt == c_CNT_LAST)) begin
            r_state <= c_IDLE;
            r_ptr   <= r_sel + 2'd1;
            r_cnt   <= '0;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Brief    : Directed self-checking bench for rr_mux_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] din;
  logic [3:0] ack;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [1:0] out_sel;
  logic       busy;

  int n_cmp;
  int n_err;

  rr_mux_arbiter #(
    .N_REQ    (4),
    .DW       (2),
    .HOLD_MAX (c_HOLD_MAX_DEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    din       = 8'b11_10_01_00;
    cyc();
    cyc();
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 2'b00) begin n_err++; $display("FAIL reset_data: got %b want 00", out_data); end
    n_cmp++; if (out_sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    cyc();
    #1;
    n_cmp++; if (out_sel !== 2'd0 || busy !== 1'b1) begin n_err++; $display("FAIL reset_first_grant: got sel=%0d busy=%b want sel=0 busy=1", out_sel, busy); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp;
    apply_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    din       = 8'b11_10_01_00;
    for (int g = 0; g < 5; g++) begin
      exp = 2'(g % 4);
      #1;
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL fair_bubble%0d: got busy=%b valid=%b want 0 0", g, busy, out_valid); end
      cyc();
      for (int b = 0; b < 4; b++) begin
        #1;
        n_cmp++;
        if (out_sel !== exp || ack !== (4'b0001 << exp) || out_data !== exp) begin
          n_err++;
          $display("FAIL fair_g%0d_b%0d: got sel=%0d ack=%b data=%b want sel=%0d ack=%b data=%b",
                   g, b, out_sel, ack, out_data, exp, 4'b0001 << exp, exp);
        end
        cyc();
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req       = 4'b0100;
    din       = 8'b00_10_00_00;
    out_ready = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 2'b10 || ack !== 4'b0000 || out_sel !== 2'd2) begin
        n_err++;
        $display("FAIL bp_hold%0d: got valid=%b data=%b ack=%b sel=%0d want 1 10 0000 2",
                 k, out_valid, out_data, ack, out_sel);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL bp_ack: got %b want 0100", ack); end
    cyc();
    req       = 4'b0000;
    out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_early_drop_and_wrap();
    apply_reset();
    req       = 4'b0010;
    out_ready = 1'b1;
    din       = 8'b11_10_01_00;
    cyc();
    req = 4'b0011;
    #1;
    n_cmp++; if (ack !== 4'b0010 || out_sel !== 2'd1) begin n_err++; $display("FAIL drop_ack1: got ack=%b sel=%0d want 0010 1", ack, out_sel); end
    cyc();
    #1;
    n_cmp++; if (ack !== 4'b0010 || out_sel !== 2'd1) begin n_err++; $display("FAIL drop_ack2: got ack=%b sel=%0d want 0010 1", ack, out_sel); end
    cyc();
    req = 4'b1001;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL drop_cycle: got valid=%b ack=%b busy=%b want 0 0000 1", out_valid, ack, busy); end
    cyc();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
    cyc();
    #1;
    n_cmp++; if (out_sel !== 2'd3 || out_data !== 2'b11) begin n_err++; $display("FAIL drop_next: got sel=%0d data=%b want 3 11", out_sel, out_data); end
    for (int b = 0; b < 4; b++) begin
      #1;
      n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL wrap_ack%0d: got %b want 1000", b, ack); end
      cyc();
    end
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_bubble: got busy=%b want 0", busy); end
    cyc();
    #1;
    n_cmp++; if (out_sel !== 2'd0 || ack !== 4'b0001) begin n_err++; $display("FAIL wrap_sel: got sel=%0d ack=%b want 0 0001", out_sel, ack); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    req       = 4'b0100;
    out_ready = 1'b1;
    cyc();
    req = 4'b0000;
    cyc();
    req = 4'b1001;
    cyc();
    #1;
    n_cmp++; if (out_sel !== 2'd3 || ack !== 4'b1000) begin n_err++; $display("FAIL mrst_pre: got sel=%0d ack=%b want 3 1000", out_sel, ack); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL mrst_ack: got %b want 0000", ack); end
    cyc();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || out_sel !== 2'd0) begin n_err++; $display("FAIL mrst_idle: got busy=%b sel=%0d want 0 0", busy, out_sel); end
    cyc();
    #1;
    n_cmp++; if (out_sel !== 2'd0 || busy !== 1'b1) begin n_err++; $display("FAIL mrst_ptr: got sel=%0d busy=%b want 0 1", out_sel, busy); end
  endtask

  task automatic test_idle_ready();
    apply_reset();
    req       = 4'b0000;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (ack !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 2'b00) begin
        n_err++;
        $display("FAIL idle_ready%0d: got ack=%b valid=%b busy=%b data=%b want all 0", k, ack, out_valid, busy, out_data);
      end
      cyc();
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    din       = 8'b0;
    out_ready = 1'b0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_early_drop_and_wrap();
    test_mid_reset();
    test_idle_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
